pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// ============================================================================
// Module   : pc_seq_ctrl
// Purpose  : Fetch/advance sequencer for Prog_Cnt with a one-deep branch buffer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        br_ready,
  output logic        o_sel,
  output logic [31:0] o_imme,
  output logic        o_pc_en,
  output logic        fetch_req,
  output logic [15:0] fetch_cnt,
  output logic        err_align,
  output logic        err_timeout
);

  localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ADVANCE = 3'd2,
    S_HOLD    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rst_done;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [31:0] r_imme_hold;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_nxt;
  logic [15:0] r_fetch_cnt;
  logic        r_err_align;
  logic        r_err_timeout;
  logic        w_accept;
  logic        w_in_adv;

  assign w_wait_nxt = r_wait_cnt + 8'd1;
  assign w_in_adv   = (r_state == S_ADVANCE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // r_rst_done delays the first departure from IDLE to the second edge after reset release
      S_IDLE:    if (start && r_rst_done) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready)                    w_state_nxt = stall ? S_HOLD : S_ADVANCE;
        else if (w_wait_nxt == c_TIMEOUT)  w_state_nxt = S_FAULT;
      end
      S_ADVANCE: w_state_nxt = S_FETCH;
      S_HOLD:    if (!stall) w_state_nxt = S_ADVANCE;
      S_FAULT:   w_state_nxt = S_FAULT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    br_ready  = ~r_pend_valid & (r_state != S_FAULT);
    o_pc_en   = w_in_adv;
    fetch_req = (r_state == S_FETCH);
    o_sel     = w_in_adv & r_pend_valid;
    o_imme    = r_imme_hold;
    if (w_in_adv) o_imme = r_pend_valid ? r_pend_target : 32'd0;
  end

  assign w_accept    = br_valid & br_ready;
  assign fetch_cnt   = r_fetch_cnt;
  assign err_align   = r_err_align;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rst_done    <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
      r_imme_hold   <= 32'd0;
      r_wait_cnt    <= 8'd0;
      r_fetch_cnt   <= 16'd0;
      r_err_align   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;

      // br_ready is low while pending, so accept and consume never coincide
      if (w_accept) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= {br_target[31:2], 2'b00};
        if (|br_target[1:0]) r_err_align <= 1'b1;
      end else if (w_in_adv) begin
        r_pend_valid <= 1'b0;
      end

      if (w_in_adv) r_imme_hold <= o_imme;

      if (r_state == S_FETCH) begin
        if (imem_ready) begin
          r_fetch_cnt <= r_fetch_cnt + 16'd1;
          r_wait_cnt  <= 8'd0;
        end else begin
          r_wait_cnt <= w_wait_nxt;
          if (w_wait_nxt == c_TIMEOUT) r_err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
// ============================================================================
// Module   : tb_pc_seq_ctrl
// Purpose  : Directed self-checking bench for pc_seq_ctrl (TIMEOUT = 4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        imem_ready;
  logic        br_valid;
  logic [31:0] br_target;
  logic        br_ready;
  logic        o_sel;
  logic [31:0] o_imme;
  logic        o_pc_en;
  logic        fetch_req;
  logic [15:0] fetch_cnt;
  logic        err_align;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] c_IDLE = 3'd0, c_FETCH = 3'd1, c_ADV = 3'd2, c_HOLD = 3'd3, c_FAULT = 3'd4;

  pc_seq_ctrl #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .br_ready    (br_ready),
    .o_sel       (o_sel),
    .o_imme      (o_imme),
    .o_pc_en     (o_pc_en),
    .fetch_req   (fetch_req),
    .fetch_cnt   (fetch_cnt),
    .err_align   (err_align),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},   {29'd0, dut.r_state}, {29'd0, c_IDLE});
    chk({tag, "_brrdy"},   {31'd0, br_ready},    32'd1);
    chk({tag, "_pcen"},    {31'd0, o_pc_en},     32'd0);
    chk({tag, "_freq"},    {31'd0, fetch_req},   32'd0);
    chk({tag, "_sel"},     {31'd0, o_sel},       32'd0);
    chk({tag, "_imme"},    o_imme,               32'd0);
    chk({tag, "_fcnt"},    {16'd0, fetch_cnt},   32'd0);
    chk({tag, "_ealign"},  {31'd0, err_align},   32'd0);
    chk({tag, "_etmo"},    {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    br_valid = 1'b0; br_target = 32'd0;

    // Reset state, with start already high
    step(); step();
    start = 1'b1;
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();
    chk("rel_edge1_idle", {29'd0, dut.r_state}, {29'd0, c_IDLE});
    step();
    chk("rel_edge2_fetch", {29'd0, dut.r_state}, {29'd0, c_FETCH});
    chk("fetch_req_on", {31'd0, fetch_req}, 32'd1);

    // Sequential run: pc_en every 2nd cycle, 3 fetches after 6 loop cycles
    imem_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("seq_pcen_%0d", i), {31'd0, o_pc_en}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("seq_sel_%0d", i), {31'd0, o_sel}, 32'd0);
    end
    chk("seq_fcnt", {16'd0, fetch_cnt}, 32'd3);

    // Aligned branch offered during FETCH while the fetch is still waiting
    imem_ready = 1'b0; br_valid = 1'b1; br_target = 32'd56;
    step();
    chk("br_rdy_drop", {31'd0, br_ready}, 32'd0);
    chk("br_still_fetch", {29'd0, dut.r_state}, {29'd0, c_FETCH});
    br_valid = 1'b0; imem_ready = 1'b1;
    step();
    chk("br_adv_pcen", {31'd0, o_pc_en}, 32'd1);
    chk("br_adv_sel", {31'd0, o_sel}, 32'd1);
    chk("br_adv_imme", o_imme, 32'd56);
    chk("br_fcnt", {16'd0, fetch_cnt}, 32'd4);
    step();
    chk("br_rdy_back", {31'd0, br_ready}, 32'd1);
    chk("br_post_sel", {31'd0, o_sel}, 32'd0);
    chk("br_post_imme_hold", o_imme, 32'd56);

    // Stall held for 5 cycles across a completed fetch
    stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("stall_state_%0d", k), {29'd0, dut.r_state}, {29'd0, c_HOLD});
      chk($sformatf("stall_pcen_%0d", k), {31'd0, o_pc_en}, 32'd0);
    end
    chk("stall_fcnt", {16'd0, fetch_cnt}, 32'd5);
    stall = 1'b0;
    step();
    chk("stall_adv_pcen", {31'd0, o_pc_en}, 32'd1);
    chk("stall_adv_sel", {31'd0, o_sel}, 32'd0);
    chk("stall_adv_imme", o_imme, 32'd0);
    step();
    chk("stall_back_fetch", {29'd0, dut.r_state}, {29'd0, c_FETCH});
    chk("stall_fcnt_once", {16'd0, fetch_cnt}, 32'd5);

    // Misaligned target accepted on the same edge the fetch completes
    br_valid = 1'b1; br_target = 32'd123;
    step();
    chk("mis_err_align", {31'd0, err_align}, 32'd1);
    chk("mis_sel", {31'd0, o_sel}, 32'd1);
    chk("mis_imme", o_imme, 32'd120);
    chk("mis_brrdy", {31'd0, br_ready}, 32'd0);
    // New offer during ADVANCE-with-pending waits one cycle
    br_target = 32'h0001_00C8;
    step();
    chk("mis_sticky", {31'd0, err_align}, 32'd1);
    chk("late_brrdy", {31'd0, br_ready}, 32'd1);
    chk("late_imme_hold", o_imme, 32'd120);
    step();
    br_valid = 1'b0;
    chk("late_adv_sel", {31'd0, o_sel}, 32'd1);
    chk("late_adv_imme_hi", o_imme, 32'h0001_00C8);
    step();
    chk("late_fetch", {29'd0, dut.r_state}, {29'd0, c_FETCH});

    // fetch_cnt wrap
    force dut.r_fetch_cnt = 16'hFFFF;
    #1;
    release dut.r_fetch_cnt;
    chk("wrap_pre", {16'd0, fetch_cnt}, 32'h0000_FFFF);
    step();
    chk("wrap_zero", {16'd0, fetch_cnt}, 32'd0);
    step();

    // Asynchronous reset between edges while a branch is pending
    imem_ready = 1'b0; br_valid = 1'b1; br_target = 32'd8;
    step();
    br_valid = 1'b0;
    chk("ar_pending", {31'd0, br_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pend_clr", {31'd0, dut.r_pend_valid}, 32'd0);
    chk_reset_vals("ar");
    step();
    rst_n = 1'b1;
    step();
    chk("ar_rel_idle", {29'd0, dut.r_state}, {29'd0, c_IDLE});
    step();
    chk("ar_rel_fetch", {29'd0, dut.r_state}, {29'd0, c_FETCH});

    // Timeout with TIMEOUT = 4
    for (int w = 1; w <= 3; w++) begin
      step();
      chk($sformatf("tmo_wait_%0d", w), {31'd0, err_timeout}, 32'd0);
      chk($sformatf("tmo_freq_%0d", w), {31'd0, fetch_req}, 32'd1);
    end
    step();
    chk("tmo_err", {31'd0, err_timeout}, 32'd1);
    chk("tmo_state", {29'd0, dut.r_state}, {29'd0, c_FAULT});
    chk("tmo_brrdy", {31'd0, br_ready}, 32'd0);
    chk("tmo_freq", {31'd0, fetch_req}, 32'd0);
    imem_ready = 1'b1; br_valid = 1'b1; br_target = 32'd4;
    step(); step();
    chk("fault_stays", {29'd0, dut.r_state}, {29'd0, c_FAULT});
    chk("fault_pcen", {31'd0, o_pc_en}, 32'd0);
    chk("fault_no_accept", {31'd0, dut.r_pend_valid}, 32'd0);
    br_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("fault_rst");
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
